regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised register file for the multi-cycle/pipelined CPU datapath: NUM_RD registered read ports,
//  one write port with write-to-read bypass, optional hardwired zero register, plus a per-register
//  busy scoreboard (set on issue, cleared on writeback) so control can stall on RAW hazards.
//  Sits between ID (read/issue) and WB (write); replaces the fixed 2-read, unscoreboarded register file.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W registers
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: register 0 reads 0, writes/issues to it ignored; 0: register 0 is ordinary
//  BYPASS    1   1: same-cycle write data forwarded to reads of that address; 0: old value returned
// PORTS
//  CLK       in   1              clock, all state updates on rising edge
//  Reset     in   1              synchronous, active-high reset
//  RdAddr    in   NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//  RdData    out  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
//  RdBusy    out  NUM_RD         registered: register read by port p still has a pending producer
//  RegWre    in   1              write enable
//  WriteReg  in   ADDR_W         write address
//  WriteData in   DATA_W         write data
//  IssueEn   in   1              mark IssueReg busy (instruction with destination issued)
//  IssueReg  in   ADDR_W         destination register being issued
//  AnyBusy   out  1              registered OR of all busy bits (drain/flush indicator)
// BEHAVIOUR
//  - Clock/reset: one clock domain; reset is synchronous and active-high; Reset takes priority over every
//    other input in the same edge.
//  - Reset: all registers <= 0, all busy bits <= 0, RdData <= 0, RdBusy <= 0, AnyBusy <= 0.
//  - Write: on edge with RegWre=1, mem[WriteReg] <= WriteData; ignored when ZERO_REG=1 and WriteReg=0.
//  - Read latency 1: RdData[p] at edge k+1 reflects RdAddr[p] sampled at edge k:
//    ZERO_REG && addr==0 -> 0; else BYPASS && RegWre && WriteReg==addr -> WriteData; else mem[addr]
//    (pre-write value). All ports independent; identical addresses on several ports legal.
//  - Scoreboard next state per register r: busy_n[r] = (busy[r] & ~(RegWre & WriteReg==r))
//    | (IssueEn & IssueReg==r). Issue and writeback to the same r in one cycle -> busy stays 1
//    (new producer wins). Issue/write to r0 ignored when ZERO_REG=1; r0 never busy then.
//  - RdBusy[p] <= busy_n[RdAddr[p]] (registered, aligned with RdData); AnyBusy <= |busy_n.
//  - Writeback to a non-busy register is legal: data written, busy unchanged (0).
//  - Re-issue to an already busy register is legal: busy stays 1 (single bit, no count).
//  - Reset mid-operation: pending writes/issues in the reset cycle are discarded.
//  - Addresses are full-range; no out-of-range case exists (depth = 2**ADDR_W).
// STRUCTURE
//  - Shared package regfile_pkg: default DATA_W/ADDR_W, REG_ZERO address constant, typedefs
//    reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
//  - One sub-module: regfile_read_port (per-port addr decode, zero/bypass mux, RdData/RdBusy regs),
//    instantiated NUM_RD times in a generate loop; storage and scoreboard stay in the top.
// TESTING
//  1. Reset, then read r1..r31 on all ports -> RdData=0, RdBusy=0, AnyBusy=0 one cycle later.
//  2. RegWre=1 WriteReg=5 WriteData=32'hDEADBEEF, RdAddr0=5 same edge -> BYPASS=1: next RdData0=
//     32'hDEADBEEF; BYPASS=0: 0, then 32'hDEADBEEF on following read.
//  3. Write r0=32'h1234 then read r0 (ZERO_REG=1) -> 0; ZERO_REG=0 -> 32'h1234.
//  4. IssueEn IssueReg=7; next cycle read r7 -> RdBusy0=1, AnyBusy=1; write r7=32'h55 -> next read
//     RdBusy0=0, RdData0=32'h55, AnyBusy=0.
//  5. Same edge IssueEn IssueReg=9 and RegWre WriteReg=9 with r9 busy -> r9 stays busy, data written.
//  6. Issue r3, write r4=32'hA5A5A5A5, assert Reset same edge -> next: r4 reads 0, r3 not busy.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
// Holds the default widths, the hardwired-zero register address and
// the register address/data typedefs used by the datapath and bench.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    // Address of the register that reads as zero when ZERO_REG is enabled
    localparam int REG_ZERO = 0;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the register file.
// Selects the read value (hardwired zero, same-cycle write bypass, or
// stored value) and registers it together with the next-state busy bit
// of the addressed register so RdData and RdBusy stay aligned.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   addr         read address sampled on the rising edge
//   mem          current register contents (pre-write values)
//   busy_next    scoreboard next-state vector
//   reg_wre, write_reg, write_data   write port, used for bypass
//   rd_data      registered read data
//   rd_busy      registered busy flag of the addressed register
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  mem,
    input  logic [(1<<ADDR_W)-1:0]              busy_next,
    input  logic                                reg_wre,
    input  logic [ADDR_W-1:0]                   write_reg,
    input  logic [DATA_W-1:0]                   write_data,
    output logic [DATA_W-1:0]                   rd_data,
    output logic                                rd_busy
);

    logic [DATA_W-1:0] read_value;

    // The zero register wins over bypass so a write to r0 can never
    // leak through the forwarding path.
    always_comb begin
        read_value = mem[addr];
        if (ZERO_REG != 0 && addr == ADDR_W'(REG_ZERO)) begin
            read_value = '0;
        end else if (BYPASS != 0 && reg_wre && write_reg == addr) begin
            read_value = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else begin
            rd_data <= read_value;
            rd_busy <= busy_next[addr];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with a per-register busy scoreboard.
// NUM_RD registered read ports, one write port with optional bypass,
// optional hardwired zero register. A register goes busy when an
// instruction writing it is issued and clears on writeback, so the
// control path can stall on RAW hazards.
// Ports:
//   CLK, Reset          clock and synchronous active-high reset
//   RdAddr / RdData     packed read addresses / registered read data
//   RdBusy              registered busy flag per read port
//   RegWre, WriteReg, WriteData   writeback port
//   IssueEn, IssueReg   destination register being issued
//   AnyBusy             registered OR of all busy bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     RegWre,
    input  logic [ADDR_W-1:0]        WriteReg,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     IssueEn,
    input  logic [ADDR_W-1:0]        IssueReg,
    output logic                     AnyBusy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busy_next;
    logic                         write_ok;
    logic                         issue_ok;

    // Accesses to the hardwired zero register are dropped entirely.
    assign write_ok = RegWre  && !(ZERO_REG != 0 && WriteReg == ADDR_W'(REG_ZERO));
    assign issue_ok = IssueEn && !(ZERO_REG != 0 && IssueReg == ADDR_W'(REG_ZERO));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mem <= '0;
        end else if (write_ok) begin
            mem[WriteReg] <= WriteData;
        end
    end

    // Issue is applied after writeback so that a new producer issued in
    // the same cycle as the old one retires keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (write_ok) begin
            busy_next[WriteReg] = 1'b0;
        end
        if (issue_ok) begin
            busy_next[IssueReg] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            busy    <= '0;
            AnyBusy <= 1'b0;
        end else begin
            busy    <= busy_next;
            AnyBusy <= |busy_next;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_read_port (
            .clk       (CLK),
            .reset     (Reset),
            .addr      (RdAddr[p*ADDR_W +: ADDR_W]),
            .mem       (mem),
            .busy_next (busy_next),
            .reg_wre   (RegWre),
            .write_reg (WriteReg),
            .write_data(WriteData),
            .rd_data   (RdData[p*DATA_W +: DATA_W]),
            .rd_busy   (RdBusy[p])
        );
    end

endmodule
